// File: rtl/eject_reassembly.sv
// eject_reassembly
//   Ejection stage behind the BLESS router local output. The router delivers
//   the flits of a packet in any order, and flits of different packets may be
//   interleaved. This block collects flits per packet ID in a small
//   reassembly table. Each complete 4-flit packet is presented to the local
//   core over a valid/ready interface. The block never stalls the router;
//   any flit it cannot store is dropped and flagged.
//
// Ports
//   clk, reset       clock and asynchronous active-low reset
//   din, din_valid   flit from router: {PKTID[6],FLITID[2],TIME[8],X[4],Y[4],DATA}
//   pkt_valid/ready  packet handshake to the core
//   pkt_id/time/dst  header of the presented packet (time/dst come from flit 0)
//   pkt_data         payload; the data of flit k is at [k*WIDTH_DATA +: WIDTH_DATA]
//   drop_ovf/dup     one-cycle pulse for a flit dropped (table full / duplicate)
//   stat_drop_cnt    saturating count of dropped flits
//   stat_pkt_cnt     wrapping count of delivered packets
//
// Build option
//   EJECT_STATS_EN   when defined, the statistics counters are implemented.
//                    When undefined, both stat ports are tied to 0.

`ifndef WIDTH_DATA
`define WIDTH_DATA 32
`endif
`ifndef WIDTH_PORT
`define WIDTH_PORT (24 + `WIDTH_DATA)
`endif

module eject_reassembly #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`WIDTH_PORT-1:0]    din,
  input  logic                      din_valid,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [5:0]                pkt_id,
  output logic [7:0]                pkt_time,
  output logic [7:0]                pkt_dst,
  output logic [4*`WIDTH_DATA-1:0]  pkt_data,
  output logic                      drop_ovf,
  output logic                      drop_dup,
  output logic [15:0]               stat_drop_cnt,
  output logic [15:0]               stat_pkt_cnt
);

  localparam int WD = `WIDTH_DATA;
  localparam int WP = `WIDTH_PORT;

  typedef enum logic [1:0] {FREE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} ent_state_t;

  // flit field decode
  logic [5:0]    f_id;
  logic [1:0]    f_flit;
  logic [7:0]    f_time, f_dst;
  logic [WD-1:0] f_data;

  assign f_id   = din[WP-1  -: 6];
  assign f_flit = din[WP-7  -: 2];
  assign f_time = din[WP-9  -: 8];
  assign f_dst  = din[WP-17 -: 8];
  assign f_data = din[WD-1:0];

  // reassembly table
  ent_state_t                       st     [NUM_ENTRIES];
  ent_state_t                       st_nxt [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0][5:0]      e_id;
  logic [NUM_ENTRIES-1:0][3:0]      e_mask;
  logic [NUM_ENTRIES-1:0][7:0]      e_time, e_dst;
  logic [NUM_ENTRIES-1:0][3:0][WD-1:0] e_data;

  logic [IDX_W-1:0] rr_ptr;

  // lookup: at most one live entry can carry a given pkt_id. The loop runs
  // from the highest index down, so the lowest index wins for both searches.
  logic             hit, free_any, hit_dup;
  logic [IDX_W-1:0] hit_idx, free_idx;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (st[i] != FREE && e_id[i] == f_id) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (st[i] == FREE) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // A flit that hits a DONE entry is also a duplicate. This covers an entry
  // being unloaded this very cycle: it only becomes FREE after the edge.
  assign hit_dup = (st[hit_idx] == DONE) || e_mask[hit_idx][f_flit];

  logic             wr, wr_alloc, ovf_nxt, dup_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_mask;

  assign wr_alloc = !hit;
  assign wr       = din_valid && (hit ? !hit_dup : free_any);
  assign wr_idx   = hit ? hit_idx : free_idx;
  assign wr_mask  = (wr_alloc ? 4'b0000 : e_mask[wr_idx]) | (4'b0001 << f_flit);
  assign ovf_nxt  = din_valid && !hit && !free_any;
  assign dup_nxt  = din_valid && hit && hit_dup;

  // round-robin pick of the next DONE entry, starting at rr_ptr
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;

  always_comb begin
    int j;
    j       = 0;
    sel_any = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_ENTRIES) j = j - NUM_ENTRIES;
      if (!sel_any && st[j] == DONE) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(j);
      end
    end
  end

  logic load, take;
  assign load = !pkt_valid || pkt_ready;
  assign take = load && sel_any;

  // Per-entry next state. Writes never target the entry being unloaded:
  // that entry is DONE, so a flit for it is treated as a duplicate.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      st_nxt[i] = st[i];
      if (take && sel_idx == IDX_W'(i))
        st_nxt[i] = FREE;
      else if (wr && wr_idx == IDX_W'(i))
        st_nxt[i] = (wr_mask == 4'b1111) ? DONE : COLLECT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) st[i] <= FREE;
      e_id   <= '0;
      e_mask <= '0;
      e_time <= '0;
      e_dst  <= '0;
      e_data <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) st[i] <= st_nxt[i];
      if (wr) begin
        e_mask[wr_idx]         <= wr_mask;
        e_data[wr_idx][f_flit] <= f_data;
        if (wr_alloc) e_id[wr_idx] <= f_id;
        if (f_flit == 2'd0) begin
          e_time[wr_idx] <= f_time;
          e_dst[wr_idx]  <= f_dst;
        end
      end
    end
  end

  // output register and drop pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_valid <= 1'b0;
      pkt_id    <= '0;
      pkt_time  <= '0;
      pkt_dst   <= '0;
      pkt_data  <= '0;
      rr_ptr    <= '0;
      drop_ovf  <= 1'b0;
      drop_dup  <= 1'b0;
    end else begin
      drop_ovf <= ovf_nxt;
      drop_dup <= dup_nxt;
      if (take) begin
        pkt_valid <= 1'b1;
        pkt_id    <= e_id[sel_idx];
        pkt_time  <= e_time[sel_idx];
        pkt_dst   <= e_dst[sel_idx];
        pkt_data  <= e_data[sel_idx];
        rr_ptr    <= (sel_idx == IDX_W'(NUM_ENTRIES-1)) ? '0 : sel_idx + 1'b1;
      end else if (load) begin
        pkt_valid <= 1'b0;
      end
    end
  end

`ifdef EJECT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_drop_cnt <= '0;
      stat_pkt_cnt  <= '0;
    end else begin
      if ((ovf_nxt || dup_nxt) && stat_drop_cnt != 16'hFFFF)
        stat_drop_cnt <= stat_drop_cnt + 16'd1;
      if (pkt_valid && pkt_ready)
        stat_pkt_cnt <= stat_pkt_cnt + 16'd1;
    end
  end
`else
  assign stat_drop_cnt = '0;
  assign stat_pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_eject_reassembly.sv
// tb_eject_reassembly
//   Table of flit vectors {pkt id, flit id, data, expected drop pulses}.
//   A per-id model assembles the expected packets. It pushes each completed
//   packet to a scoreboard queue, which a negedge monitor pops on every
//   handshake. Hand-written sequences cover latency, back-pressure and reset.

`ifndef WIDTH_DATA
`define WIDTH_DATA 32
`endif
`ifndef WIDTH_PORT
`define WIDTH_PORT (24 + `WIDTH_DATA)
`endif

module tb_eject_reassembly;
  localparam int WD = `WIDTH_DATA;
  localparam int WP = `WIDTH_PORT;
`ifdef EJECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk, reset;
  logic [WP-1:0]     din;
  logic              din_valid, pkt_valid, pkt_ready;
  logic [5:0]        pkt_id;
  logic [7:0]        pkt_time, pkt_dst;
  logic [4*WD-1:0]   pkt_data;
  logic              drop_ovf, drop_dup;
  logic [15:0]       stat_drop_cnt, stat_pkt_cnt;

  eject_reassembly #(.NUM_ENTRIES(4), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_id(pkt_id),
    .pkt_time(pkt_time), .pkt_dst(pkt_dst), .pkt_data(pkt_data),
    .drop_ovf(drop_ovf), .drop_dup(drop_dup),
    .stat_drop_cnt(stat_drop_cnt), .stat_pkt_cnt(stat_pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    id;
    logic [1:0]    flit;
    logic [WD-1:0] data;
    bit            ovf;
    bit            dup;
  } vec_t;

  typedef struct {
    logic [5:0]      id;
    logic [7:0]      tm;
    logic [7:0]      dst;
    logic [4*WD-1:0] data;
  } pkt_t;

  vec_t vecs[$];
  pkt_t exp_q[$];
  pkt_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  logic [3:0]      m_mask [64];
  logic [4*WD-1:0] m_data [64];
  logic [7:0]      m_tm   [64];
  logic [7:0]      m_dst  [64];

  function automatic logic [7:0] tm_of(logic [5:0] id, logic [1:0] f);
    return {id, f};
  endfunction

  function automatic logic [7:0] dst_of(logic [5:0] id, logic [1:0] f);
    return {f, ~id};
  endfunction

  task automatic chk(string name, logic [4*WD-1:0] act, logic [4*WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(logic [5:0] id, logic [1:0] f, bit ovf, bit dup);
    vec_t v;
    v.id = id; v.flit = f; v.data = WD'($urandom); v.ovf = ovf; v.dup = dup;
    vecs.push_back(v);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_mask[i] = 4'b0000;
    exp_q.delete();
  endtask

  // Accept the flit unless the table row says it is dropped. Push the
  // expected packet once all four flits are present.
  task automatic model(vec_t v);
    pkt_t p;
    if (!v.ovf && !v.dup) begin
      m_data[v.id][v.flit*WD +: WD] = v.data;
      if (v.flit == 2'd0) begin
        m_tm[v.id]  = tm_of(v.id, v.flit);
        m_dst[v.id] = dst_of(v.id, v.flit);
      end
      m_mask[v.id] = m_mask[v.id] | (4'b0001 << v.flit);
      if (m_mask[v.id] == 4'b1111) begin
        p.id = v.id; p.tm = m_tm[v.id]; p.dst = m_dst[v.id]; p.data = m_data[v.id];
        exp_q.push_back(p);
        m_mask[v.id] = 4'b0000;
      end
    end
  endtask

  task automatic run_vec(int lo, int hi);
    vec_t v;
    for (int i = lo; i < hi; i++) begin
      v = vecs[i];
      din = {v.id, v.flit, tm_of(v.id, v.flit), dst_of(v.id, v.flit), v.data};
      din_valid = 1'b1;
      model(v);
      @(posedge clk); #1;
      din_valid = 1'b0;
      chk($sformatf("drop_ovf row%0d", i), drop_ovf, v.ovf);
      chk($sformatf("drop_dup row%0d", i), drop_dup, v.dup);
    end
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " drained"}, exp_q.size(), 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " pkt_valid"}, pkt_valid, 0);
    chk({tag, " pkt_id"},    pkt_id, 0);
    chk({tag, " pkt_time"},  pkt_time, 0);
    chk({tag, " pkt_dst"},   pkt_dst, 0);
    chk({tag, " pkt_data"},  pkt_data, 0);
    chk({tag, " drop_ovf"},  drop_ovf, 0);
    chk({tag, " drop_dup"},  drop_dup, 0);
    chk({tag, " drop_cnt"},  stat_drop_cnt, 0);
    chk({tag, " pkt_cnt"},   stat_pkt_cnt, 0);
  endtask

  // scoreboard monitor: compare each handshaken packet with the queue head
  always @(negedge clk) begin
    if (reset && pkt_valid && pkt_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected packet: got id %0d expected none", pkt_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pkt_id",   pkt_id,   mon_e.id);
        chk("pkt_time", pkt_time, mon_e.tm);
        chk("pkt_dst",  pkt_dst,  mon_e.dst);
        chk("pkt_data", pkt_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    reset = 1'b0; din = '0; din_valid = 1'b0; pkt_ready = 1'b1;
    model_clear();

    add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 2, 0, 0); add(1, 3, 0, 0);   // 0..3
    add(2, 3, 0, 0); add(2, 1, 0, 0); add(3, 0, 0, 0); add(3, 2, 0, 0);   // 4..7
    add(3, 1, 0, 0); add(3, 3, 0, 0); add(2, 0, 0, 0); add(2, 2, 0, 0);   // 8..11
    add(5, 0, 0, 0); add(5, 2, 0, 0); add(5, 2, 0, 1); add(5, 1, 0, 0);   // 12..15
    add(5, 3, 0, 0);                                                      // 16
    add(10, 0, 0, 0); add(11, 0, 0, 0); add(12, 0, 0, 0); add(13, 0, 0, 0); // 17..20
    add(14, 0, 1, 0);                                                     // 21
    add(10, 1, 0, 0); add(10, 2, 0, 0); add(10, 3, 0, 0);                 // 22..24
    for (int f = 0; f < 4; f++) add(20, 2'(f), 0, 0);                     // 25..28
    for (int f = 0; f < 4; f++) add(21, 2'(f), 0, 0);                     // 29..32
    for (int f = 0; f < 4; f++) add(30, 2'(3 - f), 0, 0);                 // 33..36

    #12;
    chk_zero("reset");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // in-order packet with latency check
    run_vec(0, 4);
    chk("lat t+1 pkt_valid", pkt_valid, 0);
    @(posedge clk); #1;
    chk("lat t+2 pkt_valid", pkt_valid, 1);
    drain("in-order");

    // interleaved: PKTID 3 completes first and must be delivered first
    run_vec(4, 12);
    drain("interleave");

    // duplicate flit 2 of PKTID 5
    run_vec(12, 17);
    drain("dup");
    chk("stat_pkt_cnt after 4", stat_pkt_cnt, STATS ? 4 : 0);
    chk("stat_drop_cnt after dup", stat_drop_cnt, STATS ? 1 : 0);

    // back-pressure: two complete packets, core stalls for 5 cycles
    pkt_ready = 1'b0;
    run_vec(25, 33);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp queued", exp_q.size(), 2);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp hold valid c%0d", c), pkt_valid, 1);
      chk($sformatf("bp hold id c%0d", c),    pkt_id,   exp_q[0].id);
      chk($sformatf("bp hold time c%0d", c),  pkt_time, exp_q[0].tm);
      chk($sformatf("bp hold data c%0d", c),  pkt_data, exp_q[0].data);
      @(posedge clk); #1;
    end
    hs0 = hs_cnt;
    pkt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp two consecutive handshakes", hs_cnt - hs0, 2);
    chk("bp queue empty", exp_q.size(), 0);
    chk("stat_pkt_cnt after bp", stat_pkt_cnt, STATS ? 6 : 0);

    // fresh reset, then overflow: fifth distinct PKTID finds the table full
    reset = 1'b0;
    model_clear();
    #2;
    chk_zero("reset2");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    run_vec(17, 22);
    chk("stat_drop_cnt ovf", stat_drop_cnt, STATS ? 1 : 0);

    // complete PKTID 10 while the core stalls, then reset mid-operation
    pkt_ready = 1'b0;
    run_vec(22, 25);
    @(posedge clk); #1;
    chk("held pkt valid", pkt_valid, 1);
    chk("held pkt id", pkt_id, 10);
    reset = 1'b0;
    model_clear();
    #2;
    chk_zero("mid-op reset");
    @(negedge clk); reset = 1'b1; pkt_ready = 1'b1;
    @(posedge clk); #1;

    // fresh packet after reset, flits in reverse order
    run_vec(33, 37);
    chk("post-reset lat t+1", pkt_valid, 0);
    @(posedge clk); #1;
    chk("post-reset lat t+2", pkt_valid, 1);
    chk("post-reset id", pkt_id, 30);
    drain("post-reset");
    repeat (3) @(posedge clk);
    #1;
    chk("idle after drain", pkt_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
